maxpool_window_ctrl: RTL
========================

# maxpool_window_ctrl

Streaming controller that sequences a 3x3 max-pooling unit over one feature-map frame. It accepts a raster-order stream of 32-bit FP pixels and buffers two lines internally. It issues each stride-aligned 3x3 window to the pooling pipeline with a one-cycle valid strobe. It collects the returned maxima, flags the last result and reports frame completion; it sits between the feature-map reader and the 3x3 find-max pipeline in the MaxPooling path.

## Interface
- DATA_WIDTH, 32, pixel width (IEEE-754 single)
- MAX_DIM, 64, maximum image width/height; line-buffer depth
- STRIDE, 2, window stride in both axes, legal 1..3
- DIM_W, $clog2(MAX_DIM+1), width of dimension/count fields

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- Start  in  1  one-cycle frame start, sampled only in IDLE
- Img_Width  in  DIM_W  frame width, captured on accepted Start
- Img_Height  in  DIM_W  frame height, captured on accepted Start
- Pixel_In  in  DATA_WIDTH  input pixel
- Pixel_Valid  in  1  pixel present
- Pixel_Ready  out  1  controller accepts pixel; transfer = Valid & Ready
- Win_Data  out  9*DATA_WIDTH  window; slot k at [k*32+:32], slot 0 top-left, row-major, slot 8 newest pixel
- Win_Valid  out  1  window strobe to pooling unit Valid_In
- Max_Data  in  DATA_WIDTH  pooling unit Data_Out
- Max_Valid  in  1  pooling unit Valid_Out
- Out_Data  out  DATA_WIDTH  pooled result
- Out_Valid  out  1  result strobe
- Out_Last  out  1  with final result of frame
- Busy  out  1  high in RUN or DRAIN
- Done  out  1  one-cycle frame-complete pulse
- Cfg_Err  out  1  one-cycle pulse, Start rejected

## Operation
- FSM: IDLE -> RUN on Start with 3 <= Img_Width, Img_Height <= MAX_DIM; otherwise Cfg_Err pulses and the FSM stays IDLE. RUN -> DRAIN when the last pixel (row H-1, col W-1) transfers. DRAIN -> DONE when result count equals the expected count. DONE -> IDLE unconditionally; Done is high in DONE.
- Pixel_Ready = 1 only in RUN; no downstream backpressure, since the pooling pipeline has fixed latency.
- Counters col/row: col increments per transfer and wraps to 0 at W-1, which increments row.
- Line buffers LB0 (previous row) and LB1 (row before that), each MAX_DIM x DATA_WIDTH. On transfer at col c: LB1[c] <= LB0[c], LB0[c] <= pixel.
- Window register: 3 columns of 3. On transfer the window shifts left and the new right column is {LB1[c], LB0[c], pixel}, top to bottom.
- On a transfer, the window is emitted iff row >= 2, col >= 2, (row-2) mod STRIDE == 0 and (col-2) mod STRIDE == 0.
- Expected results: ((H-3)/STRIDE+1)*((W-3)/STRIDE+1), computed on Start with integer division.
- Results: in RUN/DRAIN each Max_Valid registers Max_Data to Out_Data and increments the result counter. Out_Last asserts with the result that reaches the expected count. Max_Valid in IDLE/DONE is dropped.
- Start outside IDLE is ignored: no Cfg_Err and no state change.
- The window register is not cleared at row start. Stale columns are never emitted because col >= 2 gating guarantees three fresh columns.

## Timing
- Reset values: Pixel_Ready 0, Win_Valid 0, Win_Data 0, Out_Valid 0, Out_Data 0, Out_Last 0, Busy 0, Done 0, Cfg_Err 0. All counters are 0 and the FSM is in IDLE. Line-buffer contents are don't-care.
- Start accepted at cycle t: Busy and Pixel_Ready are high from t+1.
- A qualifying pixel transferred at cycle t gives Win_Valid and Win_Data at t+1, for one cycle.
- Max_Valid at cycle t gives Out_Valid at t+1.
- Final Out_Valid/Out_Last at cycle t gives Done at t+1; IDLE at t+2, where Start can be accepted again.
- Pixel_Valid gaps stall all counters; the window register holds.
- Reset in mid-frame returns to IDLE next edge; in-flight results are discarded.

## Structure
- Shared package maxpool_pkg: FSM state enum (IDLE, RUN, DRAIN, DONE), DATA_WIDTH, window slot count 9, and the pooling pipeline latency constant (3).
- Sub-module maxpool_line_buffer: single-port-per-cycle read-then-write RAM of MAX_DIM words, instantiated twice. The FSM, counters and window register stay in the top.

## Test plan
Bench uses a behavioural 3-cycle max model on Win_Valid; pixel value = float(raster index).
- W=H=5, STRIDE=2, continuous stream -> 4 windows, Out_Data 12.0, 14.0, 22.0, 24.0; Out_Last on 24.0; Done one cycle after.
- W=H=4, STRIDE=1, random Pixel_Valid gaps -> Out_Data 10.0, 11.0, 14.0, 15.0. Each Win_Valid is exactly one cycle after its qualifying transfer.
- Img_Width=2, H=5, Start -> Cfg_Err one cycle, Busy stays 0, Pixel_Ready 0.
- Start pulsed during RUN of a 5x5 frame -> ignored; frame completes with 4 results.
- rst low at pixel 13 of a 5x5 frame -> all outputs 0 next cycle. A fresh 5x5 frame after that yields 12.0, 14.0, 22.0, 24.0, and pre-reset Max_Valid does not reach Out_Valid.
- W=64, H=3, STRIDE=3 -> 21 results: 130.0, 133.0, … 190.0.

Source files
------------

// File: rtl/maxpool_pkg.sv
// Shared types and constants for the 3x3 max-pooling window controller.
package maxpool_pkg;
   localparam int DATA_WIDTH   = 32;
   localparam int WIN_SLOTS    = 9;
   localparam int POOL_LATENCY = 3;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;
endpackage

// File: rtl/maxpool_line_buffer.sv
// One image line of pixels: asynchronous read and synchronous write at the same
// address, so a write returns the previous contents in the same cycle.
module maxpool_line_buffer #(
   parameter int DATA_WIDTH = maxpool_pkg::DATA_WIDTH,
   parameter int DEPTH      = 64,
   parameter int AW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [AW-1:0]         i_addr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   output logic [DATA_WIDTH-1:0] o_rdata
);
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   assign o_rdata = r_mem[i_addr];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
   end
endmodule

// File: rtl/maxpool_window_ctrl.sv
// Sequences a raster pixel stream into stride-aligned 3x3 windows for the
// pooling pipeline and collects the returned maxima for one frame.
module maxpool_window_ctrl #(
   parameter int DATA_WIDTH = maxpool_pkg::DATA_WIDTH,
   parameter int MAX_DIM    = 64,
   parameter int STRIDE     = 2,
   parameter int DIM_W      = $clog2(MAX_DIM + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    Start,
   input  logic [DIM_W-1:0]        Img_Width,
   input  logic [DIM_W-1:0]        Img_Height,
   input  logic [DATA_WIDTH-1:0]   Pixel_In,
   input  logic                    Pixel_Valid,
   output logic                    Pixel_Ready,
   output logic [9*DATA_WIDTH-1:0] Win_Data,
   output logic                    Win_Valid,
   input  logic [DATA_WIDTH-1:0]   Max_Data,
   input  logic                    Max_Valid,
   output logic [DATA_WIDTH-1:0]   Out_Data,
   output logic                    Out_Valid,
   output logic                    Out_Last,
   output logic                    Busy,
   output logic                    Done,
   output logic                    Cfg_Err
);
   import maxpool_pkg::*;

   localparam int AW = $clog2(MAX_DIM);
   localparam int CW = 2 * DIM_W;
   localparam logic [1:0] PH_MAX = 2'(STRIDE - 1);

   state_t                r_state;
   logic [DIM_W-1:0]      r_col, r_row, r_width, r_height;
   logic [1:0]            r_col_ph, r_row_ph;
   logic [CW-1:0]         r_exp, r_res_cnt;
   logic                  r_ready, r_win_valid, r_out_valid, r_out_last;
   logic                  r_busy, r_done, r_cfg_err;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic [DATA_WIDTH-1:0] r_win [WIN_SLOTS];

   logic [DATA_WIDTH-1:0] w_lb0_rd, w_lb1_rd;
   logic [AW-1:0]         w_addr;
   logic                  w_xfer, w_col_end, w_row_end, w_emit, w_cfg_ok, w_max_acc;
   logic [DIM_W-1:0]      w_rows_out, w_cols_out;
   logic [CW-1:0]         w_exp;

   assign w_xfer    = Pixel_Valid & r_ready;
   assign w_addr    = r_col[AW-1:0];
   assign w_col_end = (r_col == r_width - 1'b1);
   assign w_row_end = (r_row == r_height - 1'b1);
   // Phase counters track (pos-2) mod STRIDE so no divider sits in the pixel path.
   assign w_emit    = w_xfer && (r_row >= DIM_W'(2)) && (r_col >= DIM_W'(2)) &&
                      (r_row_ph == 2'd0) && (r_col_ph == 2'd0);
   assign w_cfg_ok  = (Img_Width  >= DIM_W'(3)) && (Img_Width  <= DIM_W'(MAX_DIM)) &&
                      (Img_Height >= DIM_W'(3)) && (Img_Height <= DIM_W'(MAX_DIM));
   assign w_rows_out = (Img_Height - DIM_W'(3)) / DIM_W'(STRIDE) + 1'b1;
   assign w_cols_out = (Img_Width  - DIM_W'(3)) / DIM_W'(STRIDE) + 1'b1;
   assign w_exp      = CW'(w_rows_out) * CW'(w_cols_out);
   assign w_max_acc  = Max_Valid && ((r_state == RUN) || (r_state == DRAIN));

   maxpool_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MAX_DIM), .AW(AW)) u_lb0 (
      .clk(clk), .i_we(w_xfer), .i_addr(w_addr), .i_wdata(Pixel_In), .o_rdata(w_lb0_rd)
   );

   maxpool_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MAX_DIM), .AW(AW)) u_lb1 (
      .clk(clk), .i_we(w_xfer), .i_addr(w_addr), .i_wdata(w_lb0_rd), .o_rdata(w_lb1_rd)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned k = 0; k < WIN_SLOTS; k++) r_win[k] <= '0;
      end else if (w_xfer) begin
         r_win[0] <= r_win[1];  r_win[1] <= r_win[2];  r_win[2] <= w_lb1_rd;
         r_win[3] <= r_win[4];  r_win[4] <= r_win[5];  r_win[5] <= w_lb0_rd;
         r_win[6] <= r_win[7];  r_win[7] <= r_win[8];  r_win[8] <= Pixel_In;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_col       <= '0;
         r_row       <= '0;
         r_col_ph    <= '0;
         r_row_ph    <= '0;
         r_width     <= '0;
         r_height    <= '0;
         r_exp       <= '0;
         r_res_cnt   <= '0;
         r_ready     <= 1'b0;
         r_win_valid <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_cfg_err   <= 1'b0;
      end else begin
         r_win_valid <= w_emit;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_done      <= 1'b0;
         r_cfg_err   <= 1'b0;

         if (w_max_acc) begin
            r_out_valid <= 1'b1;
            r_out_data  <= Max_Data;
            r_res_cnt   <= r_res_cnt + 1'b1;
            r_out_last  <= (r_res_cnt + 1'b1 == r_exp);
         end

         if (w_xfer) begin
            if (w_col_end) begin
               r_col    <= '0;
               r_col_ph <= '0;
               r_row    <= r_row + 1'b1;
               if (r_row >= DIM_W'(2))
                  r_row_ph <= (r_row_ph == PH_MAX) ? 2'd0 : r_row_ph + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
               if (r_col >= DIM_W'(2))
                  r_col_ph <= (r_col_ph == PH_MAX) ? 2'd0 : r_col_ph + 1'b1;
            end
         end

         case (r_state)
            IDLE: begin
               if (Start) begin
                  if (w_cfg_ok) begin
                     r_state   <= RUN;
                     r_ready   <= 1'b1;
                     r_busy    <= 1'b1;
                     r_width   <= Img_Width;
                     r_height  <= Img_Height;
                     r_exp     <= w_exp;
                     r_col     <= '0;
                     r_row     <= '0;
                     r_col_ph  <= '0;
                     r_row_ph  <= '0;
                     r_res_cnt <= '0;
                  end else begin
                     r_cfg_err <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (w_xfer && w_col_end && w_row_end) begin
                  r_state <= DRAIN;
                  r_ready <= 1'b0;
               end
            end
            DRAIN: begin
               if (r_res_cnt == r_exp) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   always_comb begin
      Win_Data = '0;
      for (int unsigned k = 0; k < WIN_SLOTS; k++)
         Win_Data[k*DATA_WIDTH +: DATA_WIDTH] = r_win[k];
   end

   assign Pixel_Ready = r_ready;
   assign Win_Valid   = r_win_valid;
   assign Out_Data    = r_out_data;
   assign Out_Valid   = r_out_valid;
   assign Out_Last    = r_out_last;
   assign Busy        = r_busy;
   assign Done        = r_done;
   assign Cfg_Err     = r_cfg_err;
endmodule
